// File: rtl/mul_add_arbiter.sv
// mul_add_arbiter: round-robin arbiter that shares one multi-cycle FP
// multiply-add unit between NUM_REQ requesters and returns tagged results.
// Optional watchdog in WAIT is enabled with `define MUL_ADD_ARB_WDOG_EN.
module mul_add_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                          clock,
  input  logic                          aclr_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dataa,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_datab,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          unit_start,
  output logic [DATA_WIDTH-1:0]         unit_dataa,
  output logic [DATA_WIDTH-1:0]         unit_datab,
  input  logic [DATA_WIDTH-1:0]         unit_result,
  input  logic                          unit_done
);

  // Reject parameter sets the index or watchdog counter cannot represent.
  if (NUM_REQ < 2 || (2 ** ID_WIDTH) < NUM_REQ) begin : g_badReqCfg
    $error("mul_add_arbiter: ID_WIDTH too narrow for NUM_REQ, or NUM_REQ < 2");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (2 ** CNT_WIDTH)) begin : g_badWdogCfg
    $error("mul_add_arbiter: CNT_WIDTH cannot hold TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;

  logic [ID_WIDTH-1:0]     r_rrPtr;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_result;

  logic [NUM_REQ-1:0]      r_gnt;
  logic                    r_unitStart;
  logic [DATA_WIDTH-1:0]   r_unitDataA;
  logic [DATA_WIDTH-1:0]   r_unitDataB;
  logic                    r_rspValid;
  logic [ID_WIDTH-1:0]     r_rspId;
  logic [DATA_WIDTH-1:0]   r_rspResult;
  logic                    r_busy;

  logic                    w_found;
  logic [ID_WIDTH-1:0]     w_winner;
  logic [DATA_WIDTH-1:0]   w_dataA;
  logic [DATA_WIDTH-1:0]   w_dataB;
  logic                    w_wdogExpired;

  // Requester index reached by stepping 'off' places past 'base', wrapping at NUM_REQ.
  function automatic int rrIndex(input int base, input int off);
    return (base + off) % NUM_REQ;
  endfunction

  // Round-robin search: scan from the requester after the last winner, first hit wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_dataA  = '0;
    w_dataB  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req[rrIndex(int'(r_rrPtr), k)]) begin
        w_found  = 1'b1;
        w_winner = ID_WIDTH'(rrIndex(int'(r_rrPtr), k));
        w_dataA  = req_dataa[rrIndex(int'(r_rrPtr), k)*DATA_WIDTH +: DATA_WIDTH];
        w_dataB  = req_datab[rrIndex(int'(r_rrPtr), k)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef MUL_ADD_ARB_WDOG_EN
  logic [CNT_WIDTH-1:0]    r_wdogCnt;
  logic                    r_timedOut;
  logic                    r_timeoutErr;

  // The watchdog fires on the last permitted WAIT cycle; a done in that same cycle wins.
  assign w_wdogExpired = (r_wdogCnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign timeout_err   = r_timeoutErr;
`else
  // Without the watchdog WAIT only ends on unit_done and no abort is ever reported.
  assign w_wdogExpired = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // State register; an asynchronous reset abandons any in-flight operation.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; unit_done only matters while waiting for the unit.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_found) w_nextState = ST_ISSUE;
      ST_ISSUE:   w_nextState = ST_WAIT;
      ST_WAIT:    if (unit_done || w_wdogExpired) w_nextState = ST_RESPOND;
      ST_RESPOND: w_nextState = ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  // Registered datapath and outputs; pulse outputs default low every cycle.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_rrPtr      <= ID_WIDTH'(NUM_REQ - 1);
      r_id         <= '0;
      r_result     <= '0;
      r_gnt        <= '0;
      r_unitStart  <= 1'b0;
      r_unitDataA  <= '0;
      r_unitDataB  <= '0;
      r_rspValid   <= 1'b0;
      r_rspId      <= '0;
      r_rspResult  <= '0;
      r_busy       <= 1'b0;
`ifdef MUL_ADD_ARB_WDOG_EN
      r_wdogCnt    <= '0;
      r_timedOut   <= 1'b0;
      r_timeoutErr <= 1'b0;
`endif
    end else begin
      r_gnt        <= '0;
      r_unitStart  <= 1'b0;
      r_rspValid   <= 1'b0;
      r_rspId      <= '0;
      r_rspResult  <= '0;
      r_busy       <= (w_nextState != ST_IDLE);
`ifdef MUL_ADD_ARB_WDOG_EN
      r_timeoutErr <= 1'b0;
`endif
      unique case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt       <= NUM_REQ'(1) << w_winner;
            r_unitStart <= 1'b1;
            r_unitDataA <= w_dataA;
            r_unitDataB <= w_dataB;
            r_id        <= w_winner;
            r_rrPtr     <= w_winner;
          end
        end
        ST_ISSUE: begin
`ifdef MUL_ADD_ARB_WDOG_EN
          r_wdogCnt   <= '0;
`endif
        end
        ST_WAIT: begin
          if (unit_done) begin
            r_result    <= unit_result;
`ifdef MUL_ADD_ARB_WDOG_EN
            r_timedOut  <= 1'b0;
          end else if (w_wdogExpired) begin
            r_result    <= '0;
            r_timedOut  <= 1'b1;
          end else begin
            r_wdogCnt   <= r_wdogCnt + 1'b1;
`endif
          end
        end
        ST_RESPOND: begin
          r_rspValid   <= 1'b1;
          r_rspId      <= r_id;
          r_rspResult  <= r_result;
`ifdef MUL_ADD_ARB_WDOG_EN
          r_timeoutErr <= r_timedOut;
`endif
        end
        default: ;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign unit_start = r_unitStart;
  assign unit_dataa = r_unitDataA;
  assign unit_datab = r_unitDataB;
  assign rsp_valid  = r_rspValid;
  assign rsp_id     = r_rspId;
  assign rsp_result = r_rspResult;
  assign busy       = r_busy;

endmodule

// File: tb/tb_mul_add_arbiter.sv
// tb_mul_add_arbiter: scoreboard bench for mul_add_arbiter with a behavioural
// multiply-add unit of programmable latency.
module tb_mul_add_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int ID_WIDTH       = 2;
  localparam int DATA_WIDTH     = 32;
  localparam int TIMEOUT_CYCLES = 32;
  localparam int CNT_WIDTH      = 6;

  typedef struct {
    int          id;
    logic [31:0] result;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        tmo;
    int          dueCycle;
  } sbEntry_t;

  logic         clock = 1'b0;
  logic         aclr_n = 1'b0;
  logic [3:0]   req = '0;
  logic [31:0]  reqA [4];
  logic [31:0]  reqB [4];
  logic [127:0] reqDataA;
  logic [127:0] reqDataB;

  logic [3:0]   gnt;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic         busy;
  logic         timeout_err;
  logic         unit_start;
  logic [31:0]  unit_dataa;
  logic [31:0]  unit_datab;
  logic [31:0]  unitRes = '0;
  logic         modelDone = 1'b0;
  logic         strayDone = 1'b0;
  logic         unitDone;

  int           assertCount = 0;
  int           failCount = 0;
  int           cycle = 0;
  int           gntCount = 0;
  int           rspCount = 0;
  int           startCount = 0;
  int           curLat = 4;
  int           modelCnt = 0;
  bit           unitMute = 1'b0;
  int           rrModel = NUM_REQ - 1;
  logic [3:0]   gntObs = '0;
  int           lastRspId = -1;
  logic [31:0]  lastRspResult = '0;
  logic         lastRspTmo = 1'b0;
  logic [31:0]  latchA = '0;
  logic [31:0]  latchB = '0;
  int           gntLog [$];
  sbEntry_t     sbQ [$];

  assign unitDone = modelDone | strayDone;

  always #5 clock = ~clock;

  // Pack the per-requester operands into the flat ports.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      reqDataA[i*32 +: 32] = reqA[i];
      reqDataB[i*32 +: 32] = reqB[i];
    end
  end

  mul_add_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clock(clock), .aclr_n(aclr_n), .req(req),
    .req_dataa(reqDataA), .req_datab(reqDataB),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .busy(busy), .timeout_err(timeout_err), .unit_start(unit_start),
    .unit_dataa(unit_dataa), .unit_datab(unit_datab),
    .unit_result(unitRes), .unit_done(unitDone)
  );

  // What the shared unit returns for a given operand pair (3.0, 2.0 gives 9.0).
  function automatic logic [31:0] unitFn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40400000 && b == 32'h40000000) return 32'h41100000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h00C0FFEE;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Unit model plus scoreboard monitor, evaluated just after each rising edge.
  always @(posedge clock) begin
    #1;
    cycle++;
    modelDone = 1'b0;
    if (modelCnt > 0) begin
      modelCnt--;
      if (modelCnt == 0 && !unitMute) begin
        modelDone = 1'b1;
        unitRes   = unitFn(latchA, latchB);
      end
    end
    if (unit_start) begin
      latchA   = unit_dataa;
      latchB   = unit_datab;
      modelCnt = curLat;
      startCount++;
    end
    gntObs = gnt;
    if (!aclr_n) begin
      sbQ.delete();
      rrModel = NUM_REQ - 1;
    end
    if (gnt != '0) begin
      int expW;
      bit found;
      sbEntry_t e;
      expW  = 0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found && req[(rrModel + k) % NUM_REQ]) begin
          found = 1'b1;
          expW  = (rrModel + k) % NUM_REQ;
        end
      end
      checkOutput("gnt_onehot", gnt, 4'b0001 << expW);
      checkOutput("gnt_start", unit_start, 1'b1);
      checkOutput("gnt_busy", busy, 1'b1);
      checkOutput("gnt_dataa", unit_dataa, reqA[expW]);
      checkOutput("gnt_datab", unit_datab, reqB[expW]);
      checkOutput("gnt_outstanding", sbQ.size(), 0);
      e.id       = expW;
      e.tmo      = unitMute;
      e.result   = unitMute ? 32'h0 : unitFn(reqA[expW], reqB[expW]);
      e.dataA    = reqA[expW];
      e.dataB    = reqB[expW];
      e.dueCycle = cycle + (unitMute ? TIMEOUT_CYCLES + 2 : curLat + 2);
      sbQ.push_back(e);
      rrModel = expW;
      gntLog.push_back(expW);
      gntCount++;
    end else if (unit_start) begin
      checkOutput("start_no_gnt", unit_start, 1'b0);
    end
    if (rsp_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        sbEntry_t e;
        e = sbQ.pop_front();
        checkOutput("rsp_id", rsp_id, e.id);
        checkOutput("rsp_result", rsp_result, e.result);
        checkOutput("rsp_timeout_err", timeout_err, e.tmo);
        checkOutput("rsp_latency", cycle, e.dueCycle);
        checkOutput("rsp_busy", busy, 1'b0);
        checkOutput("rsp_dataa_held", unit_dataa, e.dataA);
        checkOutput("rsp_datab_held", unit_datab, e.dataB);
      end
      lastRspId     = rsp_id;
      lastRspResult = rsp_result;
      lastRspTmo    = timeout_err;
      rspCount++;
    end else if (timeout_err) begin
      checkOutput("timeout_without_rsp", timeout_err, 1'b0);
    end
  end

  // One cycle at the falling edge; requesters drop req once they have seen gnt.
  task automatic tick();
    @(negedge clock);
    req = req & ~gntObs;
  endtask

  task automatic applyStimulus(input logic [3:0] mask);
    req = mask;
  endtask

  task automatic waitRsp(input string tag, input int target, input int budget);
    for (int n = 0; n < budget && rspCount < target; n++) tick();
    checkOutput(tag, rspCount, target);
  endtask

  task automatic waitGnt(input string tag, input int target, input int budget);
    for (int n = 0; n < budget && gntCount < target; n++) tick();
    checkOutput(tag, gntCount, target);
  endtask

  task automatic doReset(input string tag);
    @(negedge clock);
    aclr_n = 1'b0;
    #1;
    checkOutput({tag, "_gnt"}, gnt, 4'b0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_unit_start"}, unit_start, 1'b0);
    checkOutput({tag, "_unit_dataa"}, unit_dataa, 32'h0);
    checkOutput({tag, "_rsp_result"}, rsp_result, 32'h0);
    checkOutput({tag, "_timeout_err"}, timeout_err, 1'b0);
    @(negedge clock);
    aclr_n = 1'b1;
  endtask

  initial begin
    int base;
    int r0;
    int s0;
    for (int i = 0; i < 4; i++) begin
      reqA[i] = 32'h3F800000 + 32'(i * 32'h00110000);
      reqB[i] = 32'h40A00000 ^ 32'(i * 32'h01010101);
    end
    reqA[2] = 32'h40400000;
    reqB[2] = 32'h40000000;
    repeat (2) @(negedge clock);
    doReset("reset");

    // Stale done straight after reset, with no requests pending.
    tick();
    r0 = rspCount;
    s0 = startCount;
    strayDone = 1'b1;
    tick();
    strayDone = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      checkOutput("t4_busy", busy, 1'b0);
    end
    checkOutput("t4_no_rsp", rspCount, r0);
    checkOutput("t4_no_start", startCount, s0);

    // Single requester 2 with a 12-cycle unit.
    curLat = 12;
    s0 = startCount;
    applyStimulus(4'b0100);
    @(posedge clock);
    #2;
    checkOutput("t1_gnt", gnt, 4'b0100);
    checkOutput("t1_start", unit_start, 1'b1);
    waitRsp("t1_rsp_count", rspCount + 1, 40);
    checkOutput("t1_rsp_id", lastRspId, 2);
    checkOutput("t1_rsp_result", lastRspResult, 32'h41100000);
    checkOutput("t1_one_start", startCount - s0, 1);

    // All four requesting: strict rotation, one response per grant.
    doReset("t2_reset");
    curLat = 3;
    base = gntLog.size();
    r0 = rspCount;
    applyStimulus(4'b1111);
    for (int n = 0; n < 5; n++) begin
      waitRsp("t2_rsp_count", r0 + n + 1, 40);
      if (n < 4) req[lastRspId] = 1'b1;
      else applyStimulus(4'b0000);
    end
    tick();
    checkOutput("t2_grants", gntLog.size() - base, 5);
    for (int n = 0; n < 5 && base + n < gntLog.size(); n++)
      checkOutput("t2_order", gntLog[base + n], n % 4);

    // Requester 1 alone, then 0 and 1 together: 0 wins next, then 1.
    curLat = 1;
    base = gntLog.size();
    r0 = rspCount;
    applyStimulus(4'b0010);
    waitRsp("t3_rsp_a", r0 + 1, 20);
    applyStimulus(4'b0011);
    waitRsp("t3_rsp_b", r0 + 3, 40);
    applyStimulus(4'b0000);
    tick();
    checkOutput("t3_grants", gntLog.size() - base, 3);
    if (gntLog.size() - base == 3) begin
      checkOutput("t3_first", gntLog[base], 1);
      checkOutput("t3_second", gntLog[base + 1], 0);
      checkOutput("t3_third", gntLog[base + 2], 1);
    end

    // Reset while requester 3 waits on the unit; its late done must be dropped.
    curLat = 20;
    r0 = rspCount;
    applyStimulus(4'b1000);
    waitGnt("t5_gnt_seen", gntCount + 1, 10);
    repeat (5) tick();
    doReset("t5_reset");
    for (int n = 0; n < 25; n++) begin
      tick();
      checkOutput("t5_idle_busy", busy, 1'b0);
    end
    checkOutput("t5_no_rsp", rspCount, r0);
    curLat = 2;
    applyStimulus(4'b1001);
    waitGnt("t5_regnt", gntCount + 1, 10);
    applyStimulus(4'b0000);
    checkOutput("t5_winner", gntLog[gntLog.size() - 1], 0);
    waitRsp("t5_rsp", r0 + 1, 20);

    // Unit never answers.
    unitMute = 1'b1;
    r0 = rspCount;
    applyStimulus(4'b0010);
    waitGnt("t6_gnt", gntCount + 1, 10);
`ifdef MUL_ADD_ARB_WDOG_EN
    waitRsp("t6_wdog_rsp", r0 + 1, TIMEOUT_CYCLES + 10);
    checkOutput("t6_timeout_err", lastRspTmo, 1'b1);
    checkOutput("t6_result_zero", lastRspResult, 32'h0);
`else
    for (int n = 0; n < 60; n++) begin
      tick();
      if (n % 20 == 19) checkOutput("t6_busy_held", busy, 1'b1);
    end
    checkOutput("t6_no_rsp", rspCount, r0);
    doReset("t6_reset");
`endif
    unitMute = 1'b0;
    repeat (3) tick();
    checkOutput("final_scoreboard_empty", sbQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
